// File: rtl/spwm_pkg.sv
// rtl/spwm_pkg.sv - shared SPWM link constants, state encoding and width helper
package spwm_pkg;

    localparam int PERIOD_DEFAULT       = 256;
    localparam int IDLE_WINDOWS_DEFAULT = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // High-time counter width: must hold the value PERIOD itself (100% duty).
    function automatic int calc_cw(input int period);
        return $clog2(period) + 1;
    endfunction

    localparam int CW_DEFAULT = calc_cw(PERIOD_DEFAULT);

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - two-flop synchronizer plus rising-edge detect for one PWM leg
module pwm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic sync_out,
    output logic rise_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the asynchronous level through the synchronizer and keep one stage of history.
    always_comb begin
        meta_d = pwm_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise_out = sync_q & ~prev_q;

endmodule

// File: rtl/spwm_demod.sv
// rtl/spwm_demod.sv - recovers one signed sample per carrier window from the two H-bridge legs
module spwm_demod
    import spwm_pkg::*;
#(
    parameter int PERIOD       = PERIOD_DEFAULT,
    parameter int IDLE_WINDOWS = IDLE_WINDOWS_DEFAULT,
    localparam int CW          = calc_cw(PERIOD)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_a,
    input  logic        pwm_b,
    output logic [CW:0] sample,
    output logic        sample_valid,
    output logic        locked,
    output logic        sync_err,
    output logic        overlap_err
);

    localparam int IW = $clog2(IDLE_WINDOWS + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(PERIOD - 1);
    localparam logic [IW-1:0] LAST_IDLE  = IW'(IDLE_WINDOWS - 1);

    logic sync_a, rise_a;
    logic sync_b, rise_b;

    pwm_edge_sync u_sync_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_a),
        .sync_out (sync_a),
        .rise_out (rise_a)
    );

    pwm_edge_sync u_sync_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_b),
        .sync_out (sync_b),
        .rise_out (rise_b)
    );

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] high_a_q, high_a_d;
    logic [CW-1:0] high_b_q, high_b_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          seen_q, seen_d;
    logic [CW:0]   sample_q, sample_d;
    logic          valid_q, valid_d;
    logic          sync_err_q, sync_err_d;
    logic          overlap_q, overlap_d;

    logic [CW-1:0] sum_a, sum_b;
    logic          rise_any;

    // Window sequencing, high-time accumulation, idle tracking and sample formation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        high_a_d   = high_a_q;
        high_b_d   = high_b_q;
        idle_d     = idle_q;
        seen_d     = seen_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;
        overlap_d  = sync_a & sync_b;
        rise_any   = rise_a | rise_b;
        sum_a      = high_a_q + CW'(sync_a);
        sum_b      = high_b_q + CW'(sync_b);

        case (state_q)
            ST_IDLE: begin
                count_d  = '0;
                high_a_d = '0;
                high_b_d = '0;
                idle_d   = '0;
                seen_d   = 1'b0;
                // The aligning edge cycle is itself window count 0 and is counted.
                if (rise_any) begin
                    state_d  = ST_LOCKED;
                    count_d  = CW'(1);
                    high_a_d = CW'(sync_a);
                    high_b_d = CW'(sync_b);
                    seen_d   = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (rise_any && (count_q != '0)) begin
                    // Misaligned edge: drop the partial window and realign on this cycle.
                    sync_err_d = 1'b1;
                    count_d    = CW'(1);
                    high_a_d   = CW'(sync_a);
                    high_b_d   = CW'(sync_b);
                    seen_d     = 1'b1;
                    idle_d     = '0;
                end else if (count_q == LAST_COUNT) begin
                    sample_d = {1'b0, sum_a} - {1'b0, sum_b};
                    valid_d  = 1'b1;
                    high_a_d = '0;
                    high_b_d = '0;
                    count_d  = '0;
                    seen_d   = 1'b0;
                    if (!seen_q) begin
                        if (idle_q == LAST_IDLE) begin
                            state_d = ST_IDLE;
                            idle_d  = '0;
                        end else begin
                            idle_d = idle_q + IW'(1);
                        end
                    end
                end else begin
                    count_d  = count_q + CW'(1);
                    high_a_d = sum_a;
                    high_b_d = sum_b;
                    if (rise_any) begin
                        seen_d = 1'b1;
                        idle_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            high_a_q   <= '0;
            high_b_q   <= '0;
            idle_q     <= '0;
            seen_q     <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            overlap_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            high_a_q   <= high_a_d;
            high_b_q   <= high_b_d;
            idle_q     <= idle_d;
            seen_q     <= seen_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
            overlap_q  <= overlap_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign locked       = (state_q == ST_LOCKED);
    assign sync_err     = sync_err_q;
    assign overlap_err  = overlap_q;

endmodule

// File: tb/tb_spwm_demod.sv
// tb/tb_spwm_demod.sv - directed self-checking bench for spwm_demod
module tb_spwm_demod;

    localparam int P  = 256;
    localparam int IW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_a = 1'b0;
    logic       pwm_b = 1'b0;
    logic [9:0] sample;
    logic       sample_valid;
    logic       locked;
    logic       sync_err;
    logic       overlap_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int samp_q[$];
    int samp_cyc[$];
    int sync_err_cnt = 0;
    int overlap_cnt = 0;

    spwm_demod #(
        .PERIOD       (P),
        .IDLE_WINDOWS (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_a        (pwm_a),
        .pwm_b        (pwm_b),
        .sample       (sample),
        .sample_valid (sample_valid),
        .locked       (locked),
        .sync_err     (sync_err),
        .overlap_err  (overlap_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_valid) begin
                samp_q.push_back(int'($signed(sample)));
                samp_cyc.push_back(cyc);
            end
            if (sync_err) sync_err_cnt++;
            if (overlap_err) overlap_cnt++;
        end
    end

    task automatic run_window(input int da, input int db, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            pwm_a = (i < da);
            pwm_b = (i < db);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if (sample !== 10'd0) begin errors++; $display("FAIL reset_sample got %0d want 0", sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
        checks++; if (overlap_err !== 1'b0) begin errors++; $display("FAIL reset_overlap got %b want 0", overlap_err); end
    endtask

    task automatic test_duty_a();
        int s0 = samp_q.size();
        int e0 = sync_err_cnt;
        int o0 = overlap_cnt;
        repeat (4) run_window(23, 0, P);
        checks++;
        if (samp_q.size() - s0 !== 3) begin errors++; $display("FAIL duty_a_count got %0d want 3", samp_q.size() - s0); end
        for (int k = 0; k < 3 && s0 + k < samp_q.size(); k++) begin
            checks++;
            if (samp_q[s0+k] !== 23) begin errors++; $display("FAIL duty_a_sample[%0d] got %0d want 23", k, samp_q[s0+k]); end
            if (k > 0) begin
                checks++;
                if (samp_cyc[s0+k] - samp_cyc[s0+k-1] !== P) begin
                    errors++; $display("FAIL duty_a_spacing[%0d] got %0d want %0d", k, samp_cyc[s0+k] - samp_cyc[s0+k-1], P);
                end
            end
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL duty_a_locked got %b want 1", locked); end
        checks++; if (sync_err_cnt - e0 !== 0) begin errors++; $display("FAIL duty_a_sync_err got %0d want 0", sync_err_cnt - e0); end
        checks++; if (overlap_cnt - o0 !== 0) begin errors++; $display("FAIL duty_a_overlap got %0d want 0", overlap_cnt - o0); end
    endtask

    task automatic test_duty_b_switch();
        int exp_v[5] = '{23, -164, -164, -164, 221};
        int s0 = samp_q.size();
        int e0 = sync_err_cnt;
        repeat (3) run_window(0, 164, P);
        repeat (2) run_window(221, 0, P);
        checks++;
        if (samp_q.size() - s0 !== 5) begin errors++; $display("FAIL switch_count got %0d want 5", samp_q.size() - s0); end
        for (int k = 0; k < 5 && s0 + k < samp_q.size(); k++) begin
            checks++;
            if (samp_q[s0+k] !== exp_v[k]) begin errors++; $display("FAIL switch_sample[%0d] got %0d want %0d", k, samp_q[s0+k], exp_v[k]); end
        end
        checks++; if (sync_err_cnt - e0 !== 0) begin errors++; $display("FAIL switch_sync_err got %0d want 0", sync_err_cnt - e0); end
    endtask

    task automatic test_idle_unlock();
        int exp_v[5] = '{221, 0, 0, 0, 0};
        int s0 = samp_q.size();
        repeat (6) run_window(0, 0, P);
        checks++;
        if (samp_q.size() - s0 !== 5) begin errors++; $display("FAIL idle_count got %0d want 5", samp_q.size() - s0); end
        for (int k = 0; k < 5 && s0 + k < samp_q.size(); k++) begin
            checks++;
            if (samp_q[s0+k] !== exp_v[k]) begin errors++; $display("FAIL idle_sample[%0d] got %0d want %0d", k, samp_q[s0+k], exp_v[k]); end
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL idle_locked got %b want 0", locked); end
    endtask

    task automatic test_sync_inject();
        int exp_v[3] = '{50, 50, 10};
        int s0 = samp_q.size();
        int e0 = sync_err_cnt;
        int inj_cyc;
        repeat (2) run_window(50, 0, P);
        run_window(50, 0, 100);
        inj_cyc = cyc;
        repeat (2) run_window(10, 0, P);
        checks++;
        if (samp_q.size() - s0 !== 3) begin errors++; $display("FAIL inject_count got %0d want 3", samp_q.size() - s0); end
        for (int k = 0; k < 3 && s0 + k < samp_q.size(); k++) begin
            checks++;
            if (samp_q[s0+k] !== exp_v[k]) begin errors++; $display("FAIL inject_sample[%0d] got %0d want %0d", k, samp_q[s0+k], exp_v[k]); end
        end
        if (samp_q.size() - s0 >= 3) begin
            checks++;
            if (samp_cyc[s0+2] - inj_cyc !== P + 2) begin
                errors++; $display("FAIL inject_latency got %0d want %0d", samp_cyc[s0+2] - inj_cyc, P + 2);
            end
        end
        checks++; if (sync_err_cnt - e0 !== 1) begin errors++; $display("FAIL inject_sync_err got %0d want 1", sync_err_cnt - e0); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL inject_locked got %b want 1", locked); end
    endtask

    task automatic test_overlap();
        int o0 = overlap_cnt;
        pwm_a = 1'b1;
        pwm_b = 1'b1;
        repeat (5) @(negedge clk);
        pwm_a = 1'b0;
        pwm_b = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (overlap_cnt - o0 !== 5) begin errors++; $display("FAIL overlap_cycles got %0d want 5", overlap_cnt - o0); end
        checks++; if (overlap_err !== 1'b0) begin errors++; $display("FAIL overlap_cleared got %b want 0", overlap_err); end
    endtask

    task automatic test_reset_mid();
        int s0;
        run_window(30, 0, P);
        run_window(30, 0, 130);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (sample !== 10'd0) begin errors++; $display("FAIL midrst_sample got %0d want 0", sample); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midrst_locked got %b want 0", locked); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", sample_valid); end
        rst_n = 1'b1;
        s0 = samp_q.size();
        repeat (P + 20) @(negedge clk);
        checks++; if (samp_q.size() - s0 !== 0) begin errors++; $display("FAIL midrst_discard got %0d want 0", samp_q.size() - s0); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midrst_stay_idle got %b want 0", locked); end
        s0 = samp_q.size();
        repeat (2) run_window(30, 0, P);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_locked got %b want 1", locked); end
        checks++;
        if (samp_q.size() - s0 !== 1) begin errors++; $display("FAIL relock_count got %0d want 1", samp_q.size() - s0); end
        else if (samp_q[s0] !== 30) begin errors++; $display("FAIL relock_sample got %0d want 30", samp_q[s0]); end
    endtask

    task automatic test_full_scale();
        int s0;
        int e0;
        pwm_a = 1'b0;
        pwm_b = 1'b0;
        repeat (8) @(negedge clk);
        s0 = samp_q.size();
        e0 = sync_err_cnt;
        pwm_b = 1'b1;
        repeat (6 * P) @(negedge clk);
        checks++;
        if (samp_q.size() - s0 !== 5) begin errors++; $display("FAIL full_count got %0d want 5", samp_q.size() - s0); end
        for (int k = 0; k < 5 && s0 + k < samp_q.size(); k++) begin
            checks++;
            if (samp_q[s0+k] !== -P) begin errors++; $display("FAIL full_sample[%0d] got %0d want %0d", k, samp_q[s0+k], -P); end
        end
        checks++; if (sync_err_cnt - e0 !== 1) begin errors++; $display("FAIL full_sync_err got %0d want 1", sync_err_cnt - e0); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL full_locked got %b want 0", locked); end
        checks++; if (sample !== 10'h300) begin errors++; $display("FAIL full_hold got %h want 300", sample); end
        pwm_b = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_duty_a();
        test_duty_b_switch();
        test_idle_unlock();
        test_sync_inject();
        test_overlap();
        test_reset_mid();
        test_full_scale();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
